// File: rtl/mcycle_seq_if.sv
// Sequencer handshake bundle: control inputs from decode/memory, timing outputs to address/decode logic.
interface mcycle_seq_if #(
    parameter int unsigned N_STATES = 6,
    parameter int unsigned CYC_W    = 2
);
    localparam int unsigned SW = $clog2(N_STATES + 1);

    logic [CYC_W-1:0] instr_cycles;
    logic             fetch_ready;
    logic             skip_fetch;
    logic             hold_req;
    logic [SW-1:0]    state_idx;
    logic             phase;
    logic             ALE;
    logic             PSEN;
    logic             opcode_latch;
    logic             data_latch;
    logic             decode_strobe;
    logic             pc_inc;
    logic [CYC_W-1:0] cycle_cnt;
    logic             instr_done;
    logic             hold_ack;

    modport master (
        output instr_cycles, fetch_ready, skip_fetch, hold_req,
        input  state_idx, phase, ALE, PSEN, opcode_latch, data_latch,
        input  decode_strobe, pc_inc, cycle_cnt, instr_done, hold_ack
    );

    modport slave (
        input  instr_cycles, fetch_ready, skip_fetch, hold_req,
        output state_idx, phase, ALE, PSEN, opcode_latch, data_latch,
        output decode_strobe, pc_inc, cycle_cnt, instr_done, hold_ack
    );
endinterface

// File: rtl/mcycle_seq.sv
// Parametrised MCU51 machine-cycle sequencer: state/phase timing, fetch strobes,
// wait states, dummy-fetch suppression, cycle counting and hold handshake.
module mcycle_seq #(
    parameter int unsigned CLK_PER_PHASE = 1,
    parameter int unsigned N_STATES      = 6,
    parameter int unsigned CYC_W         = 2
) (
    input  logic       clk,
    input  logic       reset,
    mcycle_seq_if.slave bus
);
    localparam int unsigned SW = $clog2(N_STATES + 1);
    localparam int unsigned TW = (CLK_PER_PHASE > 1) ? $clog2(CLK_PER_PHASE) : 1;
    localparam int unsigned K  = N_STATES / 2;

    localparam logic [TW-1:0] TC_LAST = TW'(CLK_PER_PHASE - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(N_STATES);
    localparam logic [SW-1:0] S_K     = SW'(K);
    localparam logic [SW-1:0] S_ONE   = SW'(1);
    localparam logic [SW-1:0] S_TWO   = SW'(2);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} mode_t;

    mode_t            mode_q, mode_d;
    logic [SW-1:0]    st_q, st_d;
    logic             ph_q, ph_d;
    logic [TW-1:0]    tc_q, tc_d;
    logic             first_q, first_d;
    logic             skip_q, skip_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    loc_q, loc_d;
    logic             fetch_d, latch_d, done_d, ale_d, op_d;
    logic             ale_q, psen_q, op_q, dat_q, dec_q, pc_q, done_q;

    // Next position and the registered output values for the clock being entered.
    always_comb begin
        mode_d  = mode_q;
        st_d    = st_q;
        ph_d    = ph_q;
        tc_d    = tc_q;
        first_d = first_q;
        skip_d  = skip_q;
        cnt_d   = cnt_q;
        loc_q   = (st_q > S_K) ? st_q - S_K : st_q;

        if (mode_q == HOLD) begin
            if (!bus.hold_req) begin
                mode_d  = RUN;
                st_d    = S_ONE;
                ph_d    = 1'b0;
                tc_d    = '0;
                first_d = 1'b1;
            end
        end else if (tc_q != TC_LAST) begin
            tc_d = tc_q + TW'(1);
        end else begin
            tc_d = '0;
            if (!ph_q) begin
                ph_d = 1'b1;
            end else if (loc_q == S_K && !skip_q && !(op_q || dat_q)) begin
                ph_d = 1'b0;  // wait state: replay LK P1
            end else begin
                ph_d = 1'b0;
                if (st_q == S_LAST) begin
                    st_d = S_ONE;
                    if (done_q) begin
                        first_d = 1'b1;
                        if (bus.hold_req) begin
                            mode_d = HOLD;
                            st_d   = '0;
                        end
                    end else begin
                        first_d = 1'b0;
                        cnt_d   = cnt_q - CYC_W'(1);
                    end
                end else begin
                    st_d = st_q + S_ONE;
                end
            end
        end

        if (op_q) cnt_d = bus.instr_cycles;

        loc_d = (st_d > S_K) ? st_d - S_K : st_d;
        if (mode_d == RUN && loc_d == S_ONE && !ph_d && tc_d == '0)
            skip_d = bus.skip_fetch && !(first_d && st_d <= S_K);

        fetch_d = (mode_d == RUN) && (loc_d == S_K) && !skip_d;
        latch_d = fetch_d && ph_d && (tc_d == TC_LAST) && bus.fetch_ready;
        op_d    = latch_d && first_d && (st_d <= S_K);
        done_d  = (mode_d == RUN) && (st_d == S_LAST) && ph_d && (tc_d == TC_LAST)
                  && (latch_d || skip_d) && (cnt_d == '0);
        ale_d   = (mode_d == RUN) && ((loc_d == S_ONE && ph_d) || (loc_d == S_TWO && !ph_d));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q  <= RUN;
            st_q    <= S_ONE;
            ph_q    <= 1'b0;
            tc_q    <= '0;
            first_q <= 1'b1;
            skip_q  <= 1'b0;
            cnt_q   <= '0;
            ale_q   <= 1'b0;
            psen_q  <= 1'b1;
            op_q    <= 1'b0;
            dat_q   <= 1'b0;
            dec_q   <= 1'b0;
            pc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            st_q    <= st_d;
            ph_q    <= ph_d;
            tc_q    <= tc_d;
            first_q <= first_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
            ale_q   <= ale_d;
            psen_q  <= !fetch_d;
            op_q    <= op_d;
            dat_q   <= latch_d && !op_d;
            dec_q   <= op_q;
            pc_q    <= latch_d;
            done_q  <= done_d;
        end
    end

    assign bus.state_idx     = st_q;
    assign bus.phase         = ph_q;
    assign bus.ALE           = ale_q;
    assign bus.PSEN          = psen_q;
    assign bus.opcode_latch  = op_q;
    assign bus.data_latch    = dat_q;
    assign bus.decode_strobe = dec_q;
    assign bus.pc_inc        = pc_q;
    assign bus.cycle_cnt     = cnt_q;
    assign bus.instr_done    = done_q;
    assign bus.hold_ack      = (mode_q == HOLD);
endmodule

// File: tb/tb_mcycle_seq.sv
// Bench for mcycle_seq: default timing, multi-cycle, wait, skip and hold on one instance,
// and a CLK_PER_PHASE=2 / N_STATES=8 instance with a mid-fetch reset.
module tb_mcycle_seq;
    logic clk = 1'b0;
    logic reset;
    logic reset1;
    always #5 clk = ~clk;

    mcycle_seq_if #(.N_STATES(6), .CYC_W(2)) b0 ();
    mcycle_seq_if #(.N_STATES(8), .CYC_W(2)) b1 ();

    mcycle_seq #(.CLK_PER_PHASE(1), .N_STATES(6), .CYC_W(2)) dut0 (
        .clk(clk), .reset(reset), .bus(b0)
    );
    mcycle_seq #(.CLK_PER_PHASE(2), .N_STATES(8), .CYC_W(2)) dut1 (
        .clk(clk), .reset(reset1), .bus(b1)
    );

    typedef struct {int kind; int at;} ev_t;  // kind: 0 opcode, 1 data, 2 decode, 3 done
    ev_t sb0[$];
    ev_t sb1[$];
    int  total = 0;
    int  bad = 0;
    int  clk_no = 0;
    int  pc0 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at = at;
        if (d == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    task automatic see(input int d, input int kind);
        ev_t e;
        e.kind = -1;
        e.at = -1;
        if (d == 0 && sb0.size() > 0) e = sb0.pop_front();
        if (d == 1 && sb1.size() > 0) e = sb1.pop_front();
        chk($sformatf("dut%0d_pulse_k%0d", d, kind), 32'(kind * 1000 + clk_no),
            32'(e.kind * 1000 + e.at));
    endtask

    task automatic push_instr(input int d, input int op, input int dec, input int last);
        push(d, 0, op);
        push(d, 2, dec);
        if (last >= 0) begin
            push(d, 1, last);
            push(d, 3, last);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clk_no++;
        if (b0.opcode_latch) see(0, 0);
        if (b0.data_latch) see(0, 1);
        if (b0.decode_strobe) see(0, 2);
        if (b0.instr_done) see(0, 3);
        if (b0.pc_inc) pc0++;
        if (b1.opcode_latch) see(1, 0);
        if (b1.data_latch) see(1, 1);
        if (b1.decode_strobe) see(1, 2);
        if (b1.instr_done) see(1, 3);
    endtask

    task automatic run_to(input int n);
        while (clk_no < n) tick();
    endtask

    initial begin
        reset = 1'b0;
        reset1 = 1'b0;
        b0.instr_cycles = 2'd0; b0.fetch_ready = 1'b1; b0.skip_fetch = 1'b0; b0.hold_req = 1'b0;
        b1.instr_cycles = 2'd0; b1.fetch_ready = 1'b1; b1.skip_fetch = 1'b0; b1.hold_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(b0.state_idx), 32'd1);
        chk("rst_phase", 32'(b0.phase), 32'd0);
        chk("rst_ale", 32'(b0.ALE), 32'd0);
        chk("rst_psen", 32'(b0.PSEN), 32'd1);
        chk("rst_cnt", 32'(b0.cycle_cnt), 32'd0);
        chk("rst_pulses", 32'({b0.opcode_latch, b0.data_latch, b0.decode_strobe,
                               b0.pc_inc, b0.instr_done, b0.hold_ack}), 32'd0);

        // Instruction 1: single machine cycle, clocks 0..11
        reset = 1'b1;
        reset1 = 1'b1;
        clk_no = 0;
        push_instr(0, 5, 6, 11);
        for (int c = 0; c <= 12; c++) begin
            run_to(c);
            chk($sformatf("i1_ale_c%0d", c), 32'(b0.ALE), 32'(c == 1 || c == 2 || c == 7 || c == 8));
            chk($sformatf("i1_psen_c%0d", c), 32'(b0.PSEN), 32'(!(c == 4 || c == 5 || c == 10 || c == 11)));
            chk($sformatf("w_ale_c%0d", c), 32'(b1.ALE), 32'(c >= 2 && c <= 5));
            chk($sformatf("w_psen_c%0d", c), 32'(b1.PSEN), 32'(c != 12));
        end
        chk("i2_state_c12", 32'(b0.state_idx), 32'd1);

        // Instruction 2: three machine cycles, clocks 12..47
        b0.instr_cycles = 2'd2;
        push_instr(0, 17, 18, -1);
        push(0, 1, 23); push(0, 1, 29); push(0, 1, 35); push(0, 1, 41);
        push(0, 1, 47); push(0, 3, 47);

        // Wide instance: reset in the middle of the opcode fetch
        run_to(13);
        reset1 = 1'b0;
        #1;
        chk("w_rst_state", 32'(b1.state_idx), 32'd1);
        chk("w_rst_phase", 32'(b1.phase), 32'd0);
        chk("w_rst_psen", 32'(b1.PSEN), 32'd1);
        chk("w_rst_ale", 32'(b1.ALE), 32'd0);
        run_to(14);
        reset1 = 1'b1;
        push_instr(1, 29, 30, 45);
        push_instr(1, 61, 62, 77);
        push_instr(1, 93, 94, -1);

        run_to(20);
        chk("i2_cnt_mc1", 32'(b0.cycle_cnt), 32'd2);
        b0.instr_cycles = 2'd0;
        run_to(32);
        chk("i2_cnt_mc2", 32'(b0.cycle_cnt), 32'd1);
        run_to(44);
        chk("i2_cnt_mc3", 32'(b0.cycle_cnt), 32'd0);

        // Instruction 3: four wait clocks on the opcode fetch, base 48
        run_to(48);
        push_instr(0, 57, 58, 63);
        for (int c = 52; c <= 59; c++) begin
            run_to(c);
            if (c == 52) b0.fetch_ready = 1'b0;
            if (c == 56) b0.fetch_ready = 1'b1;
            chk($sformatf("i3_psen_c%0d", c), 32'(b0.PSEN), 32'(c >= 58));
            if (c == 55) chk("i3_wait_state", 32'(b0.state_idx), 32'd3);
        end

        // Instruction 4: slot B dummy fetch, base 64
        run_to(64);
        push_instr(0, 69, 70, -1);
        push(0, 3, 75);
        run_to(69);
        b0.skip_fetch = 1'b1;
        run_to(71);
        b0.skip_fetch = 1'b0;
        chk("i4_ale_c71", 32'(b0.ALE), 32'd1);
        run_to(72);
        chk("i4_ale_c72", 32'(b0.ALE), 32'd1);
        run_to(74);
        chk("i4_psen_c74", 32'(b0.PSEN), 32'd1);
        run_to(75);
        chk("i4_psen_c75", 32'(b0.PSEN), 32'd1);

        // Instruction 5: hold requested at its end, base 76
        run_to(76);
        push_instr(0, 81, 82, 87);
        run_to(85);
        b0.hold_req = 1'b1;
        run_to(88);
        chk("hold_ack_c88", 32'(b0.hold_ack), 32'd1);
        chk("hold_state_c88", 32'(b0.state_idx), 32'd0);
        chk("hold_ale_psen", 32'({b0.ALE, b0.PSEN}), 32'b01);
        run_to(90);
        chk("hold_ack_c90", 32'(b0.hold_ack), 32'd1);
        b0.hold_req = 1'b0;
        run_to(91);
        chk("resume_ack", 32'(b0.hold_ack), 32'd0);
        chk("resume_state", 32'(b0.state_idx), 32'd1);
        chk("resume_phase", 32'(b0.phase), 32'd0);
        push_instr(0, 96, 97, 102);

        run_to(105);
        chk("pc_inc_count", 32'(pc0), 32'd15);
        chk("sb0_drained", 32'(sb0.size()), 32'd0);
        chk("sb1_drained", 32'(sb1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
